// File: rtl/arb2_pkg.sv
// Shared types for the two-input packet arbiter: FSM state encoding and
// the select values exported to the downstream mux.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/out_reg_slice.sv
// Single-entry valid/ready output register. The payload is {sel, last, data}.
// A load and a drain in the same cycle overwrite the entry.
module out_reg_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH+1:0] load_data_i,
  input  logic             out_ready_i,
  output logic             load_en_o,
  output logic             out_valid_o,
  output logic [WIDTH+1:0] out_payload_o
);

  logic             valid_q;
  logic [WIDTH+1:0] payload_q;

  assign load_en_o     = !valid_q || out_ready_i;
  assign out_valid_o   = valid_q;
  assign out_payload_o = payload_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= load_data_i;
    end else if (out_ready_i) begin
      valid_q   <= 1'b0;
    end
  end

endmodule

// File: rtl/arb2_stream_mux.sv
// Round-robin packet arbiter for two valid/ready streams. Grant is held for a
// whole packet; the winning beat is registered together with its source select.
module arb2_stream_mux
  import arb2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             load_en;
  logic             grant_a, grant_b;
  logic             acc_a, acc_b;
  logic [WIDTH+1:0] load_data;
  logic [WIDTH+1:0] out_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= SEL_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (acc_a && !a_last) state_d = LOCK_A;
        if (acc_b && !b_last) state_d = LOCK_B;
      end
      LOCK_A: if (acc_a && a_last) state_d = IDLE;
      LOCK_B: if (acc_b && b_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Priority flips only when a packet finishes, handing the tie to the other source.
    if (acc_a && a_last) prio_d = SEL_B;
    if (acc_b && b_last) prio_d = SEL_A;
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || prio_q == SEL_A)) grant_a = 1'b1;
        else if (b_valid)                             grant_b = 1'b1;
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
    a_ready = load_en && grant_a && !rst;
    b_ready = load_en && grant_b && !rst;
  end

  assign acc_a     = a_valid && a_ready;
  assign acc_b     = b_valid && b_ready;
  assign load_data = acc_b ? {SEL_B, b_last, b_data} : {SEL_A, a_last, a_data};

  out_reg_slice #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (acc_a || acc_b),
    .load_data_i  (load_data),
    .out_ready_i  (out_ready),
    .load_en_o    (load_en),
    .out_valid_o  (out_valid),
    .out_payload_o(out_payload)
  );

  assign out_sel  = out_payload[WIDTH+1];
  assign out_last = out_payload[WIDTH];
  assign out_data = out_payload[WIDTH-1:0];

endmodule

// File: tb/tb_arb2_stream_mux.sv
// Directed bench for arb2_stream_mux: an 8-bit instance for arbitration and
// flow control, and a 16-bit instance for a back-to-back width check.
module tb_arb2_stream_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_valid, a_last, a_ready, b_valid, b_last, b_ready;
  logic [7:0] a_data, b_data, out_data;
  logic       out_valid, out_last, out_sel, out_ready;

  logic        w_a_valid, w_a_last, w_a_ready, w_b_valid, w_b_last, w_b_ready;
  logic [15:0] w_a_data, w_b_data, w_out_data;
  logic        w_out_valid, w_out_last, w_out_sel, w_out_ready;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  arb2_stream_mux #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  arb2_stream_mux #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .a_valid(w_a_valid), .a_data(w_a_data), .a_last(w_a_last), .a_ready(w_a_ready),
    .b_valid(w_b_valid), .b_data(w_b_data), .b_last(w_b_last), .b_ready(w_b_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_last(w_out_last),
    .out_sel(w_out_sel), .out_ready(w_out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 0; a_last = 0; a_data = 8'h00;
    b_valid = 0; b_last = 0; b_data = 8'h00;
    out_ready = 1;
    w_a_valid = 0; w_a_last = 0; w_a_data = 16'h0000;
    w_b_valid = 0; w_b_last = 0; w_b_data = 16'h0000;
    w_out_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({out_valid, out_data, out_last, out_sel} !== 11'h0) begin
      $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%b, want all zero",
               out_valid, out_data, out_last, out_sel);
    end else pass_cnt++;
    a_valid = 1; b_valid = 1; a_last = 1; b_last = 1;
    #1;
    chk_cnt++;
    if ({a_ready, b_ready} !== 2'b10) begin
      $display("FAIL reset_prio_a: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    a_valid = 1; a_data = 8'h01; a_last = 0;
    step();
    a_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL midrst_valid: got %b, want 0", out_valid);
    end else pass_cnt++;
    b_valid = 1; b_data = 8'hB1; b_last = 1;
    #1;
    chk_cnt++;
    if ({a_ready, b_ready} !== 2'b01) begin
      $display("FAIL midrst_grant_b: got a_ready=%b b_ready=%b, want 0 1", a_ready, b_ready);
    end else pass_cnt++;
    step();
    b_valid = 0;
    chk_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'hB1}) begin
      $display("FAIL midrst_b_beat: got v=%b s=%b d=%h, want 1 1 b1",
               out_valid, out_sel, out_data);
    end else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d;
    do_reset();
    a_valid = 1; a_data = 8'hA0; a_last = 1;
    b_valid = 1; b_data = 8'hB0; b_last = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_d = (k % 2 == 1) ? 8'hB0 : 8'hA0;
      chk_cnt++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'(k % 2), exp_d}) begin
        $display("FAIL alternate[%0d]: got v=%b s=%b d=%h, want 1 %0d %h",
                 k, out_valid, out_sel, out_data, k % 2, exp_d);
      end else pass_cnt++;
    end
    clear_inputs();
  endtask

  task automatic test_packet_lock();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h12; seq[2] = 8'h13;
    do_reset();
    b_valid = 1; b_data = 8'hB7; b_last = 1;
    a_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_data = seq[k];
      a_last = (k == 2);
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b10) begin
        $display("FAIL lock_ready[%0d]: got a_ready=%b b_ready=%b, want 1 0",
                 k, a_ready, b_ready);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if ({out_sel, out_last, out_data} !== {1'b0, 1'(k == 2), seq[k]}) begin
        $display("FAIL lock_beat[%0d]: got s=%b l=%b d=%h, want 0 %0d %h",
                 k, out_sel, out_last, out_data, k == 2, seq[k]);
      end else pass_cnt++;
    end
    a_valid = 0;
    step();
    chk_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'hB7}) begin
      $display("FAIL lock_then_b: got v=%b s=%b d=%h, want 1 1 b7",
               out_valid, out_sel, out_data);
    end else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    a_valid = 1; a_data = 8'h5A; a_last = 1;
    step();
    a_data = 8'h5B;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b00) begin
        $display("FAIL bp_ready[%0d]: got a_ready=%b b_ready=%b, want 0 0", k, a_ready, b_ready);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
        $display("FAIL bp_hold[%0d]: got v=%b d=%h, want 1 5a", k, out_valid, out_data);
      end else pass_cnt++;
    end
    out_ready = 1;
    #1;
    chk_cnt++;
    if (a_ready !== 1'b1) begin
      $display("FAIL bp_release_ready: got %b, want 1", a_ready);
    end else pass_cnt++;
    step();
    a_valid = 0;
    chk_cnt++;
    if ({out_valid, out_data} !== {1'b1, 8'h5B}) begin
      $display("FAIL bp_next_beat: got v=%b d=%h, want 1 5b", out_valid, out_data);
    end else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    b_valid = 1; b_data = 8'hC1; b_last = 0;
    step();
    b_valid = 0;
    a_valid = 1; a_data = 8'hAA; a_last = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_cnt++;
      if (a_ready !== 1'b0) begin
        $display("FAIL stall_a_ready[%0d]: got %b, want 0", k, a_ready);
      end else pass_cnt++;
      step();
    end
    chk_cnt++;
    if ({out_valid, out_sel} !== 2'b01) begin
      $display("FAIL stall_drained: got v=%b s=%b, want 0 1", out_valid, out_sel);
    end else pass_cnt++;
    b_valid = 1; b_data = 8'hC2; b_last = 1;
    #1;
    chk_cnt++;
    if ({a_ready, b_ready} !== 2'b01) begin
      $display("FAIL stall_resume: got a_ready=%b b_ready=%b, want 0 1", a_ready, b_ready);
    end else pass_cnt++;
    step();
    b_valid = 0;
    chk_cnt++;
    if ({out_sel, out_last, out_data} !== {1'b1, 1'b1, 8'hC2}) begin
      $display("FAIL stall_b_last: got s=%b l=%b d=%h, want 1 1 c2", out_sel, out_last, out_data);
    end else pass_cnt++;
    step();
    a_valid = 0;
    chk_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'hAA}) begin
      $display("FAIL stall_then_a: got v=%b s=%b d=%h, want 1 0 aa",
               out_valid, out_sel, out_data);
    end else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_width16();
    logic [15:0] exp_d;
    do_reset();
    w_a_valid = 1;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 2 == 0) ? 16'hFFFF : (16'h8000 | 16'(k));
      w_a_data = exp_d;
      w_a_last = (k == 9);
      step();
      chk_cnt++;
      if ({w_out_valid, w_out_sel, w_out_last, w_out_data} !== {1'b1, 1'b0, 1'(k == 9), exp_d})
      begin
        $display("FAIL w16_beat[%0d]: got v=%b s=%b l=%b d=%h, want 1 0 %0d %h",
                 k, w_out_valid, w_out_sel, w_out_last, w_out_data, k == 9, exp_d);
      end else pass_cnt++;
    end
    w_a_valid = 0;
    step();
    chk_cnt++;
    if (w_out_valid !== 1'b0) begin
      $display("FAIL w16_drain: got %b, want 0", w_out_valid);
    end else pass_cnt++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_mid_packet();
    test_alternate();
    test_packet_lock();
    test_backpressure();
    test_stall();
    test_width16();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/arb2_stream_mux.md
Name: arb2_stream_mux

Overview:
- Two-input packet arbiter that sits directly upstream of the 2:1 data mux and drives its select.
- Accepts two valid/ready streams (A, B) with end-of-packet markers and grants one source round-robin.
- Holds the grant for a whole packet and presents the chosen beat through a one-entry output register with valid/ready.
- Exports the registered select so the downstream mux and debug logic see which source owns the output.

Parameters:
- WIDTH, 8, data width of each stream in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  source A beat valid.
- a_data  input  WIDTH  source A data.
- a_last  input  1  source A beat is last of packet.
- a_ready  output  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid  input  1  source B beat valid.
- b_data  input  WIDTH  source B data.
- b_last  input  1  source B beat is last of packet.
- b_ready  output  1  B beat accepted this cycle when b_valid && b_ready.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered beat data.
- out_last  output  1  registered beat last flag.
- out_sel  output  1  registered source of current beat (0 = A, 1 = B); drives mux select.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge): state = IDLE, prio = 0 (A preferred), out_valid = 0, out_data = 0, out_last = 0, out_sel = 0. rst overrides every other event, including mid-packet; no beat is accepted or emitted during the reset cycle, and a partial packet is abandoned.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en is high.
- States:
  - IDLE: no packet owned.
  - LOCK_A: A owns the output until its last beat is accepted.
  - LOCK_B: B owns the output until its last beat is accepted.
- IDLE grant:
  - Only a_valid high: grant A. Only b_valid high: grant B.
  - Both high: grant the source selected by prio.
  - Grant is combinational. a_ready = load_en && grant_a, and likewise for B. Ready may depend on valid. At most one ready is high per cycle.
- On accepting a beat in IDLE:
  - with last = 0: move to LOCK_A or LOCK_B;
  - with last = 1 (single-beat packet): stay in IDLE.
- LOCK_A: a_ready = load_en, b_ready = 0. When A's last beat is accepted, return to IDLE and set prio = 1 (B preferred). LOCK_B is symmetric and sets prio = 0.
- prio also toggles when a single-beat packet completes in IDLE. prio changes only when a packet completes, never on a non-last beat.
- Accepted beat: on the next edge out_valid = 1, and out_data, out_last and out_sel are loaded from the granted source. Latency from input handshake to out_valid is 1 cycle.
- Output drain: out_valid && out_ready with no new load gives out_valid = 0 next cycle. Drain and load in the same cycle overwrites the register, so full throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, both readies are 0 and out_data, out_last and out_sel stay stable.
- A source dropping valid mid-packet keeps the lock; the other source waits (no timeout).
- out_sel changes only when a new beat is loaded.

Decomposition:
- Shared package arb2_pkg:
  - state enum (IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2);
  - SEL_A = 1'b0, SEL_B = 1'b1.
- Sub-module out_reg_slice (WIDTH+2-bit single-entry valid/ready register holding data, last, sel). The arbiter FSM and grant logic live in the top module.

Test Plan:
- Reset mid-packet: A sends a beat with last = 0, then rst = 1 for one cycle. Required next cycle: out_valid = 0, state IDLE, prio = 0, and a B request is granted with out_sel = 0→1 on the following load.
- Simultaneous single-beat requests after reset: a_valid = b_valid = 1 with last = 1 every cycle and out_ready = 1. Required: out_sel sequence 0,1,0,1, out_data alternating A/B values (8'hA0, 8'hB0, ...), one beat per cycle.
- Packet lock: A sends 3 beats (8'h11, 8'h12, 8'h13 with last) while b_valid = 1 throughout. Required: b_ready = 0 for all 3 accept cycles, out_sel = 0 for those beats, then B's beat is granted next with out_sel = 1.
- Backpressure: out_ready = 0 for 4 cycles with out_valid = 1 holding 8'h5A. Required: out_data stays 8'h5A, a_ready = b_ready = 0; after out_ready = 1, the next beat appears 1 cycle later.
- Source stall mid-packet: B sends a non-last beat, b_valid drops for 3 cycles, A stays valid. Required: a_ready = 0 throughout the stall; B's last beat completes the packet before A is granted.
- Width/throughput check: WIDTH = 16, a stream of 10 back-to-back beats from A only. Required: 10 outputs in 10 consecutive cycles with 16'hFFFF passed intact.
